// File: rtl/seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// seq_chunk_adder
//   Multi-cycle add/subtract unit. Two WIDTH-bit operands are combined CHUNK
//   bits per clock, least-significant chunk first. The carry between chunks
//   is held in a register, so one operation takes NCYC = WIDTH/CHUNK cycles
//   behind a start/done handshake.
//
//   Optional feature macro: SEQ_ADD_OVF_EN
//     defined   -> port ovf exists and reports signed overflow of each result
//     undefined -> port ovf and its logic are absent
//
// Parameters
//   WIDTH  operand/result width (multiple of CHUNK)
//   CHUNK  bits processed per clock (1 <= CHUNK <= WIDTH)
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous reset, active low
//   start  in   request, sampled only while busy is low
//   sub    in   0: a+b+c_in   1: a-b-c_in (c_in is borrow-in)
//   a, b   in   operands, captured on the accepting edge
//   c_in   in   carry-in / borrow-in, captured on the accepting edge
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse, result valid from this cycle
//   sum    out  result, held until the next done
//   c_out  out  carry out of the MSB (for subtraction 1 = no borrow)
//   ovf    out  signed overflow (only with SEQ_ADD_OVF_EN)
// -----------------------------------------------------------------------------
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SEQ_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCYC  = WIDTH / CHUNK;
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);
  localparam int MSB   = WIDTH - 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SEQ_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Operand chunks viewed as arrays so the active slice can be selected by cnt.
  logic [CHUNK-1:0] a_chunk [NCYC];
  logic [CHUNK-1:0] b_chunk [NCYC];

  genvar gi;
  generate
    for (gi = 0; gi < NCYC; gi++) begin : g_chunk
      assign a_chunk[gi] = opa_q[gi*CHUNK +: CHUNK];
      assign b_chunk[gi] = opb_q[gi*CHUNK +: CHUNK];
    end
  endgenerate

  logic [CHUNK-1:0] slice_a, slice_b, slice_part;
  logic             slice_cy;

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int k = 0; k < NCYC; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        slice_a = a_chunk[k];
        slice_b = b_chunk[k];
      end
    end
  end

  // The only adder in the design: one CHUNK-wide ripple slice.
  assign {slice_cy, slice_part} = {1'b0, slice_a} + {1'b0, slice_b}
                                + {{CHUNK{1'b0}}, carry_q};

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
`ifdef SEQ_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + ~borrow, so invert B and the carry once here.
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? ~c_in : c_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int k = 0; k < NCYC; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            shadow_d[k*CHUNK +: CHUNK] = slice_part;
          end
        end
        carry_d = slice_cy;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // shadow_d already holds the final slice, so the visible result is
          // updated in one step and never shows partial sums.
          sum_d   = shadow_d;
          cout_d  = slice_cy;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
`ifdef SEQ_ADD_OVF_EN
          ovf_d   = (opa_q[MSB] == opb_q[MSB]) && (shadow_d[MSB] != opa_q[MSB]);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SEQ_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
`ifdef SEQ_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy  = (state_q == S_RUN);
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = cout_q;
`ifdef SEQ_ADD_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// tb_seq_chunk_adder
//   Directed and random stimulus for seq_chunk_adder. Expected results come
//   from plain (WIDTH+1)-bit arithmetic on the operands; the ovf checks are
//   compiled in only when SEQ_ADD_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_chunk_adder;

  localparam int WIDTH = 32;
  localparam int CHUNK = 4;
  localparam int NCYC  = WIDTH / CHUNK;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sub   = 1'b0;
  logic             c_in  = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             busy, done, c_out;
  logic [WIDTH-1:0] sum;
`ifdef SEQ_ADD_OVF_EN
  logic             ovf;
`endif

  int checks   = 0;
  int failures = 0;

  // Value the result port must keep until the next completion.
  logic [WIDTH-1:0] held_sum = '0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
`ifdef SEQ_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: ordinary two's-complement add/subtract with carry/borrow.
  function automatic void model(input logic s, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                input logic ci, output logic [WIDTH-1:0] r,
                                output logic co, output logic ov);
    logic [WIDTH:0] full;
    if (!s) begin
      full = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
      co   = full[WIDTH];
      ov   = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    end else begin
      full = {1'b0, x} - {1'b0, y} - (WIDTH+1)'(ci);
      co   = ~full[WIDTH];
      ov   = (x[WIDTH-1] != y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    end
    r = full[WIDTH-1:0];
  endfunction

  // Called at #1 after the accepting edge; waits for done and checks it.
  task automatic wait_done(input string tag, input logic [WIDTH-1:0] es,
                           input logic ec, input logic eo);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < NCYC + 4) begin
      check({tag, ".hold"}, 64'(sum), 64'(held_sum));
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".latency"}, 64'(cyc), 64'(NCYC));
    check({tag, ".sum"}, 64'(sum), 64'(es));
    check({tag, ".c_out"}, 64'(c_out), 64'(ec));
`ifdef SEQ_ADD_OVF_EN
    check({tag, ".ovf"}, 64'(ovf), 64'(eo));
`else
    if (eo === 1'bx) checks = checks;
`endif
    held_sum = es;
  endtask

  task automatic run_op(input string tag, input logic s, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input logic ci,
                        input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    @(negedge clk);
    start = 1'b1; sub = s; a = x; b = y; c_in = ci;
    @(posedge clk); #1;
    check({tag, ".busy"}, 64'(busy), 64'(1));
    // Inputs are free to change after the accept edge.
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    sub   = 1'($urandom);
    c_in  = 1'($urandom);
    wait_done(tag, es, ec, eo);
    $display("op %s sub=%0d a=%h b=%h c_in=%0d -> sum=%h c_out=%0d", tag, s, x, y, ci, sum, c_out);
  endtask

  task automatic run_rand(input string tag, input logic s, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic ci);
    logic [WIDTH-1:0] r;
    logic co, ov;
    model(s, x, y, ci, r, co, ov);
    run_op(tag, s, x, y, ci, r, co, ov);
  endtask

  initial begin : stim
    // Reset state
    repeat (2) @(negedge clk);
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.done", 64'(done), 64'(0));
    check("rst.sum", 64'(sum), 64'(0));
    check("rst.c_out", 64'(c_out), 64'(0));
`ifdef SEQ_ADD_OVF_EN
    check("rst.ovf", 64'(ovf), 64'(0));
`endif
    rst_n = 1'b1;

    // Directed corner cases
    run_op("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("pulse.done", 64'(done), 64'(0));
    check("pulse.busy", 64'(busy), 64'(0));
    run_op("sub_neg", 1'b1, 32'h5, 32'h7, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_borrow", 1'b1, 32'h5, 32'h7, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("sub_ovf", 1'b1, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // start held high while busy: ignored, then re-accepted in the done cycle
    @(negedge clk);
    start = 1'b1; sub = 1'b0; c_in = 1'b0; a = 32'h10; b = 32'h20;
    @(posedge clk); #1;
    check("hold_start.busy", 64'(busy), 64'(1));
    a = 32'hFF; b = 32'hFF;
    wait_done("hold_start", 32'h30, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("reaccept.busy", 64'(busy), 64'(1));
    check("reaccept.done", 64'(done), 64'(0));
    start = 1'b0;
    wait_done("reaccept", 32'h1FE, 1'b0, 1'b0);
    $display("op hold_start/reaccept -> sum=%h c_out=%0d", sum, c_out);

    // Back-to-back: second request issued during the done cycle
    run_op("b2b_first", 1'b0, 32'h100, 32'h23, 1'b0, 32'h123, 1'b0, 1'b0);
    run_op("b2b_second", 1'b0, 32'h3, 32'h4, 1'b0, 32'h7, 1'b0, 1'b0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; sub = 1'b0; c_in = 1'b0; a = 32'hAAAA; b = 32'h5555;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort.busy", 64'(busy), 64'(0));
    check("abort.done", 64'(done), 64'(0));
    check("abort.sum", 64'(sum), 64'(0));
    check("abort.c_out", 64'(c_out), 64'(0));
`ifdef SEQ_ADD_OVF_EN
    check("abort.ovf", 64'(ovf), 64'(0));
`endif
    held_sum = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 1'b0, 32'h1234, 32'h1111, 1'b0, 32'h2345, 1'b0, 1'b0);

    // Random operations against the arithmetic model
    for (int i = 0; i < 16; i++) begin
      run_rand($sformatf("rand%0d", i), 1'($urandom), WIDTH'($urandom),
               WIDTH'($urandom), 1'($urandom));
    end
    @(posedge clk); #1;
    check("final.done", 64'(done), 64'(0));
    check("final.busy", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
